main_mem_wait: RTL and testbench

MAIN_MEM_WAIT -- requirements
Module: main_mem_wait

---
 rtl/main_mem_wait.sv | 117 +++++++++++
 tb/tb_main_mem_wait.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_wait.sv
// Wait-state main memory model for the cache controller.
// A single outstanding request is held in BUSY for LATENCY cycles, driven by a
// controller-owned load/count counter; ctrsig tells the controller the wait
// is over and, for reads, that mrdata is valid.
module main_mem_wait #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mstrobe,
    input  logic              mrw,
    input  logic [ADDR_W-1:0] maddr,
    input  logic [DATA_W-1:0] mwdata,
    input  logic              ldctr,
    output logic              ctrsig,
    output logic [DATA_W-1:0] mrdata,
    output logic              mbusy,
    output logic              merr
);
    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_rw_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] mrdata_q;
    logic              merr_q;
    logic              access;

    logic [DATA_W-1:0] mem [DEPTH];

    // Counter next state: a load always wins, otherwise count down and stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (ldctr)
            cnt_d = CNT_LOAD;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_ONE;
    end

    // Wait counter register
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= CNT_LOAD;
        else
            cnt_q <= cnt_d;
    end

    // The access happens on the last counting edge, so ctrsig and mrdata line up
    assign access = (state_q == BUSY) && !ldctr && (cnt_q == CNT_ONE);

    // Request FSM: latch in IDLE, wait in BUSY, hold the result in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            mrdata_q    <= '0;
            merr_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mstrobe) begin
                        req_rw_q    <= mrw;
                        req_addr_q  <= maddr;
                        req_wdata_q <= mwdata;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    // A strobe while a request is in flight is a protocol error; it is dropped
                    if (mstrobe)
                        merr_q <= 1'b1;
                    if (ldctr) begin
                        state_q <= IDLE;
                    end else if (access) begin
                        state_q <= DONE;
                        if (!req_rw_q)
                            mrdata_q <= mem[req_addr_q];
                    end
                end
                DONE: begin
                    if (mstrobe)
                        merr_q <= 1'b1;
                    if (ldctr)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory array write port; contents survive reset, and reset cancels a pending write
    always_ff @(posedge clk) begin
        if (!reset && access && req_rw_q)
            mem[req_addr_q] <= req_wdata_q;
    end

    assign ctrsig = (cnt_q == '0) && !ldctr;
    assign mrdata = mrdata_q;
    assign mbusy  = (state_q != IDLE);
    assign merr   = merr_q;

endmodule

// File: tb/tb_main_mem_wait.sv
// Randomised bench for main_mem_wait with a transaction-level reference model
// (memory image, last read data, sticky error) plus a LATENCY=1 build.
module tb_main_mem_wait;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset, mstrobe, mrw, ldctr;
    logic [7:0]  maddr;
    logic [31:0] mwdata;
    logic        ctrsig, mbusy, merr;
    logic [31:0] mrdata;

    logic        rs1, st1, rw1, ld1;
    logic [7:0]  ad1;
    logic [31:0] wd1;
    logic        cs1, bz1, er1;
    logic [31:0] rd1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mm [256];
    bit          known [256];
    logic [31:0] m_rdata;
    logic        m_err;

    main_mem_wait #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mstrobe(mstrobe), .mrw(mrw), .maddr(maddr),
        .mwdata(mwdata), .ldctr(ldctr), .ctrsig(ctrsig), .mrdata(mrdata),
        .mbusy(mbusy), .merr(merr)
    );

    main_mem_wait #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rs1), .mstrobe(st1), .mrw(rw1), .maddr(ad1),
        .mwdata(wd1), .ldctr(ld1), .ctrsig(cs1), .mrdata(rd1),
        .mbusy(bz1), .merr(er1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on the LATENCY=4 instance. Cycle 0 is the strobe cycle; cycles
    // 1..LAT+1 count, cycle LAT+2 returns to IDLE. abort_at/ovl_at/rst_at = 0 means none.
    task automatic run_txn(input string tag, input bit rw, input logic [7:0] addr,
                           input logic [31:0] wd, input int abort_at, input int ovl_at,
                           input logic [7:0] ovl_addr, input int rst_at);
        int   e;
        bit   completed;
        logic exp_b, exp_c;
        e = (abort_at != 0) ? abort_at : rst_at;
        completed = (e == 0);
        tick();
        reset = 1'b0; mstrobe = 1'b1; mrw = rw; maddr = addr; mwdata = wd; ldctr = 1'b1;
        #1;
        n_cmp++;
        if (mbusy !== 1'b0 || ctrsig !== 1'b0) begin
            n_bad++;
            $display("FAIL %s c0 mbusy/ctrsig got %b/%b want 0/0", tag, mbusy, ctrsig);
        end
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            mstrobe = 1'b0;
            ldctr   = (c == abort_at) || (c == LAT + 2);
            reset   = (c == rst_at);
            mrw     = 1'($urandom_range(0, 1));
            maddr   = 8'($urandom);
            mwdata  = $urandom;
            if (c == ovl_at) begin
                mstrobe = 1'b1;
                maddr   = ovl_addr;
            end
            #1;
            exp_b = completed || (c <= e);
            exp_c = completed && (c >= LAT + 1) && !ldctr;
            n_cmp++;
            if (mbusy !== exp_b) begin
                n_bad++;
                $display("FAIL %s c%0d mbusy got %b want %b", tag, c, mbusy, exp_b);
            end
            n_cmp++;
            if (ctrsig !== exp_c) begin
                n_bad++;
                $display("FAIL %s c%0d ctrsig got %b want %b", tag, c, ctrsig, exp_c);
            end
            n_cmp++;
            if (mrdata !== m_rdata) begin
                n_bad++;
                $display("FAIL %s c%0d mrdata got %h want %h", tag, c, mrdata, m_rdata);
            end
            n_cmp++;
            if (merr !== m_err) begin
                n_bad++;
                $display("FAIL %s c%0d merr got %b want %b", tag, c, merr, m_err);
            end
            // effect of the coming edge on the model
            if (mstrobe && exp_b) m_err = 1'b1;
            if (completed && c == LAT) begin
                if (rw) begin
                    mm[addr]    = wd;
                    known[addr] = 1'b1;
                end else begin
                    m_rdata = mm[addr];
                end
            end
            if (c == rst_at) begin
                m_rdata = '0;
                m_err   = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mstrobe = 1'b0; mrw = 1'b0; maddr = '0; mwdata = '0; ldctr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        m_rdata = '0; m_err = 1'b0;
        n_cmp++;
        if (mbusy !== 1'b0 || merr !== 1'b0 || mrdata !== 32'h0 || ctrsig !== 1'b0) begin
            n_bad++;
            $display("FAIL reset busy/err/rdata/ctrsig got %b/%b/%h/%b want 0/0/0/0",
                     mbusy, merr, mrdata, ctrsig);
        end
    endtask

    // Idle counting: after a load the counter reaches zero LAT cycles later
    task automatic test_counter();
        logic exp;
        tick();
        ldctr = 1'b1;
        #1;
        n_cmp++;
        if (ctrsig !== 1'b0) begin
            n_bad++;
            $display("FAIL counter_load ctrsig got %b want 0", ctrsig);
        end
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            ldctr = 1'b0;
            #1;
            exp = (k >= LAT + 1);
            n_cmp++;
            if (ctrsig !== exp) begin
                n_bad++;
                $display("FAIL counter k%0d ctrsig got %b want %b", k, ctrsig, exp);
            end
        end
        tick();
        ldctr = 1'b1;
        #1;
        n_cmp++;
        if (ctrsig !== 1'b0) begin
            n_bad++;
            $display("FAIL counter_reload ctrsig got %b want 0", ctrsig);
        end
    endtask

    task automatic test_preload();
        run_txn("pre20", 1'b1, 8'h20, 32'hA5A5_0020, 0, 0, 8'h0, 0);
        run_txn("pre30", 1'b1, 8'h30, 32'h3333_3333, 0, 0, 8'h0, 0);
        run_txn("pre40", 1'b1, 8'h40, 32'h4444_4444, 0, 0, 8'h0, 0);
    endtask

    task automatic test_write_read();
        run_txn("wr10", 1'b1, 8'h10, 32'hDEAD_BEEF, 0, 0, 8'h0, 0);
        run_txn("rd10", 1'b0, 8'h10, 32'h0, 0, 0, 8'h0, 0);
        run_txn("wr11_hold", 1'b1, 8'h11, 32'h0BAD_F00D, 0, 0, 8'h0, 0);
        run_txn("rd30", 1'b0, 8'h30, 32'h0, 0, 0, 8'h0, 0);
    endtask

    task automatic test_abort();
        run_txn("abort20", 1'b1, 8'h20, 32'h1234_5678, 2, 0, 8'h0, 0);
        run_txn("rd20_after_abort", 1'b0, 8'h20, 32'h0, 0, 0, 8'h0, 0);
        run_txn("abort_rd10", 1'b0, 8'h10, 32'h0, LAT, 0, 8'h0, 0);
    endtask

    task automatic test_overlap();
        run_txn("overlap", 1'b1, 8'h50, 32'h5555_AAAA, 0, 2, 8'h30, 0);
        run_txn("rd30_after_ovl", 1'b0, 8'h30, 32'h0, 0, 0, 8'h0, 0);
        run_txn("rd50_after_ovl", 1'b0, 8'h50, 32'h0, 0, 0, 8'h0, 0);
        run_txn("ovl_in_done", 1'b0, 8'h20, 32'h0, 0, LAT + 1, 8'h31, 0);
    endtask

    task automatic test_reset_busy();
        run_txn("rst_busy40", 1'b1, 8'h40, 32'hCAFE_0040, 0, 0, 8'h0, 3);
        run_txn("rd40_after_rst", 1'b0, 8'h40, 32'h0, 0, 0, 8'h0, 0);
    endtask

    task automatic test_random();
        bit          rw;
        logic [7:0]  a;
        int          ab, ov, rs;
        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            if (!rw)
                while (!known[a]) a = 8'($urandom);
            ab = 0; ov = 0; rs = 0;
            if ($urandom_range(0, 4) == 0) ab = $urandom_range(1, LAT);
            else if ($urandom_range(0, 7) == 0) rs = $urandom_range(1, LAT);
            if (rs == 0 && $urandom_range(0, 3) == 0)
                ov = $urandom_range(1, (ab != 0) ? ab : LAT + 1);
            run_txn("random", rw, a, $urandom, ab, ov, 8'($urandom), rs);
        end
    endtask

    // LATENCY=1 build: ctrsig and read data two cycles after the strobe
    task automatic test_lat1();
        logic [31:0] d;
        logic [7:0]  a;
        tick();
        rs1 = 1'b1;
        tick();
        rs1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'(i + 5);
            d = $urandom;
            for (int ph = 0; ph < 2; ph++) begin
                tick();
                st1 = 1'b1; rw1 = (ph == 0); ad1 = a; wd1 = d; ld1 = 1'b1;
                tick();
                st1 = 1'b0; ld1 = 1'b0;
                #1;
                n_cmp++;
                if (cs1 !== 1'b0 || bz1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL lat1 c1 ctrsig/mbusy got %b/%b want 0/1", cs1, bz1);
                end
                tick();
                #1;
                n_cmp++;
                if (cs1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL lat1 c2 ctrsig got %b want 1", cs1);
                end
                if (ph == 1) begin
                    n_cmp++;
                    if (rd1 !== d) begin
                        n_bad++;
                        $display("FAIL lat1 c2 mrdata got %h want %h", rd1, d);
                    end
                end
                tick();
                ld1 = 1'b1;
            end
        end
    endtask

    initial begin
        rs1 = 1'b1; st1 = 1'b0; rw1 = 1'b0; ad1 = '0; wd1 = '0; ld1 = 1'b1;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        test_reset();
        test_counter();
        test_preload();
        test_write_read();
        test_abort();
        test_overlap();
        test_reset_busy();
        test_random();
        test_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
